adc_threshold_monitor: RTL and testbench

Downstream consumer of the ADC capture stage: takes each 14-bit sample strobed by `adc_data_valid`/`adc_data_value` and keeps a moving average over the last 2^AVG_LOG2 samples. It compares each average against programmable high and low limits and debounces out-of-range averages. It latches a safety fault that the supervisor logic uses to shut down the laser/motion path.

---
 rtl/adc_monitor_pkg.sv | 20 ++
 rtl/sample_ring_buffer.sv | 41 ++++
 rtl/adc_threshold_monitor.sv | 162 ++++++++++++++++
 tb/tb_adc_threshold_monitor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_monitor_pkg.sv
// Shared definitions for the ADC threshold monitor: sample width,
// supervisor FSM states and fault cause codes.
package adc_monitor_pkg;

  localparam int SAMPLE_W = 14;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    ARMED   = 2'd1,
    TRIPPED = 2'd2
  } mon_state_e;

  typedef enum logic [1:0] {
    FC_NONE  = 2'b00,
    FC_OVER  = 2'b01,
    FC_UNDER = 2'b10,
    FC_CFG   = 2'b11
  } fault_code_e;

endpackage

// File: rtl/sample_ring_buffer.sv
// Circular sample store for the moving average. The entry under the write
// pointer is always the oldest one, so it is what the next write evicts.
// window_ready_o tells the caller that a write now completes (or follows)
// a full window of samples.
module sample_ring_buffer #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 14
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] oldest_o,
  output logic             window_ready_o
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FILL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] FILL_LAST = FILL_FULL - 1'b1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2:0]   fill_q;

  // Write newest over oldest, advance the wrapping pointer, count fill-up.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
      wr_ptr_q        <= wr_ptr_q + 1'b1;
      if (fill_q != FILL_FULL) fill_q <= fill_q + 1'b1;
    end
  end

  assign oldest_o       = mem_q[wr_ptr_q];
  assign window_ready_o = (fill_q >= FILL_LAST);

endmodule

// File: rtl/adc_threshold_monitor.sv
// Moving-average threshold monitor with debounced, latched safety fault.
// Stage 1 keeps the running window sum and publishes the average; stage 2
// compares it against the limits, runs the debounce counter and the
// WARMUP/ARMED/TRIPPED supervisor FSM.
module adc_threshold_monitor
  import adc_monitor_pkg::*;
#(
  parameter int AVG_LOG2   = 3,
  parameter int TRIP_COUNT = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                sample_valid,
  input  logic [15:0]         sample_data,
  input  logic [SAMPLE_W-1:0] thresh_hi,
  input  logic [SAMPLE_W-1:0] thresh_lo,
  input  logic                fault_clear,
  output logic                avg_valid,
  output logic [SAMPLE_W-1:0] avg_value,
  output logic                over_limit,
  output logic                under_limit,
  output logic                fault,
  output logic [1:0]          fault_code
);

  localparam int              SUM_W    = SAMPLE_W + AVG_LOG2;
  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] TRIP_CNT = CNT_W'(TRIP_COUNT);

  logic [SAMPLE_W-1:0] sample_in;
  logic [SAMPLE_W-1:0] oldest;
  logic                window_ready;
  logic                unused_upper;

  assign sample_in    = sample_data[SAMPLE_W-1:0];
  assign unused_upper = ^sample_data[15:SAMPLE_W];

  sample_ring_buffer #(
    .DEPTH_LOG2 (AVG_LOG2),
    .WIDTH      (SAMPLE_W)
  ) u_ring (
    .clk            (clk),
    .rstn           (rstn),
    .wr_en_i        (sample_valid),
    .wr_data_i      (sample_in),
    .oldest_o       (oldest),
    .window_ready_o (window_ready)
  );

  // ---- stage 1: running sum and average ----
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                avg_valid_q, avg_valid_d;
  logic [SAMPLE_W-1:0] avg_value_q;

  // The sum always contains the evicted entry, so the subtraction cannot wrap.
  assign sum_d       = sum_q + SUM_W'(sample_in) - SUM_W'(oldest);
  assign avg_valid_d = sample_valid & window_ready;

  // Update the window sum per sample; publish the average once the window is full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum_q       <= '0;
      avg_valid_q <= 1'b0;
      avg_value_q <= '0;
    end else begin
      avg_valid_q <= avg_valid_d;
      if (sample_valid) sum_q <= sum_d;
      if (avg_valid_d) avg_value_q <= sum_d[SUM_W-1:AVG_LOG2];
    end
  end

  // ---- stage 2: limit compare, debounce, supervisor FSM ----
  logic             over_now, under_now, out_of_range, cfg_err;
  logic             avg_trip, trip_now, clear_ok;
  logic             over_q, under_q;
  logic [CNT_W-1:0] dbnc_q, dbnc_d;
  mon_state_e       state_q, state_d;
  fault_code_e      code_q, code_d, trip_code;

  assign over_now     = (avg_value_q > thresh_hi);
  assign under_now    = (avg_value_q < thresh_lo);
  assign out_of_range = over_now | under_now;
  assign cfg_err      = (thresh_lo > thresh_hi);
  assign avg_trip     = avg_valid_q & out_of_range & (dbnc_d == TRIP_CNT);
  assign trip_now     = cfg_err | avg_trip;
  assign trip_code    = cfg_err ? FC_CFG : (over_now ? FC_OVER : FC_UNDER);
  // Clearing needs the last average in range, and consistent limits for a config fault.
  assign clear_ok     = fault_clear && (dbnc_q == '0) && ((code_q != FC_CFG) || !cfg_err);

  // Debounce counter, saturating so it can keep counting while tripped.
  always_comb begin
    dbnc_d = dbnc_q;
    if (avg_valid_q) begin
      if (!out_of_range)          dbnc_d = '0;
      else if (dbnc_q >= TRIP_CNT) dbnc_d = TRIP_CNT;
      else                         dbnc_d = dbnc_q + 1'b1;
    end
  end

  // Next-state and fault-code logic; a trip always beats a clear.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      WARMUP: begin
        if (avg_valid_d) state_d = ARMED;
      end
      ARMED: begin
        if (trip_now) begin
          state_d = TRIPPED;
          code_d  = trip_code;
        end
      end
      TRIPPED: begin
        if (clear_ok) begin
          if (trip_now) begin
            code_d = trip_code;
          end else begin
            state_d = ARMED;
            code_d  = FC_NONE;
          end
        end
      end
      default: begin
        state_d = WARMUP;
        code_d  = FC_NONE;
      end
    endcase
  end

  // State, fault code and debounce registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= WARMUP;
      code_q  <= FC_NONE;
      dbnc_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      dbnc_q  <= dbnc_d;
    end
  end

  // Limit flags reflect the most recent average and hold between strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      over_q  <= 1'b0;
      under_q <= 1'b0;
    end else if (avg_valid_q) begin
      over_q  <= over_now;
      under_q <= under_now;
    end
  end

  assign avg_valid   = avg_valid_q;
  assign avg_value   = avg_value_q;
  assign over_limit  = over_q;
  assign under_limit = under_q;
  assign fault       = (state_q == TRIPPED);
  assign fault_code  = code_q;

endmodule

// File: tb/tb_adc_threshold_monitor.sv
// Directed bench for adc_threshold_monitor (AVG_LOG2=3, TRIP_COUNT=4).
module tb_adc_threshold_monitor;

  logic        clk;
  logic        rstn;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic [13:0] thresh_hi;
  logic [13:0] thresh_lo;
  logic        fault_clear;
  logic        avg_valid;
  logic [13:0] avg_value;
  logic        over_limit;
  logic        under_limit;
  logic        fault;
  logic [1:0]  fault_code;

  adc_threshold_monitor #(
    .AVG_LOG2   (3),
    .TRIP_COUNT (4)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .thresh_hi    (thresh_hi),
    .thresh_lo    (thresh_lo),
    .fault_clear  (fault_clear),
    .avg_valid    (avg_valid),
    .avg_value    (avg_value),
    .over_limit   (over_limit),
    .under_limit  (under_limit),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        av;
    logic [13:0] avg;
    logic        over;
    logic        under;
    logic        flt;
    logic [1:0]  code;
  } vec_t;

  vec_t        tbl [16];
  int          tests = 0;
  int          fails = 0;
  logic        s1_av;
  logic [13:0] s1_avg;
  int          pulses;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One sample strobe; returns at N+2 with the N+1 outputs captured.
  task automatic feed(input logic [15:0] d);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = d;
    @(negedge clk);
    sample_valid = 1'b0;
    s1_av  = avg_valid;
    s1_avg = avg_value;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; sample_valid = 1'b0; sample_data = '0;
    thresh_hi = 14'd1500; thresh_lo = 14'd0; fault_clear = 1'b0;

    // Warm-up with 0xC3E8 (low 14 bits = 1000), then a 2000 step over hi=1500.
    for (int i = 0; i < 7; i++) tbl[i] = '{16'hC3E8, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[7]  = '{16'hC3E8, 1'b1, 14'd1000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[8]  = '{16'd2000, 1'b1, 14'd1125, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[9]  = '{16'd2000, 1'b1, 14'd1250, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[10] = '{16'd2000, 1'b1, 14'd1375, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[11] = '{16'd2000, 1'b1, 14'd1500, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[12] = '{16'd2000, 1'b1, 14'd1625, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[13] = '{16'd2000, 1'b1, 14'd1750, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[14] = '{16'd2000, 1'b1, 14'd1875, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[15] = '{16'd2000, 1'b1, 14'd2000, 1'b1, 1'b0, 1'b1, 2'd1};

    repeat (3) @(negedge clk);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_avg_value", avg_value, 0);
    chk("rst_over", over_limit, 0);
    chk("rst_under", under_limit, 0);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    rstn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      feed(tbl[i].data);
      chk($sformatf("tbl%0d_avg_valid", i), s1_av, tbl[i].av);
      chk($sformatf("tbl%0d_avg_value", i), s1_avg, tbl[i].avg);
      chk($sformatf("tbl%0d_pulse_end", i), avg_valid, 0);
      chk($sformatf("tbl%0d_over", i), over_limit, tbl[i].over);
      chk($sformatf("tbl%0d_under", i), under_limit, tbl[i].under);
      chk($sformatf("tbl%0d_fault", i), fault, tbl[i].flt);
      chk($sformatf("tbl%0d_code", i), fault_code, tbl[i].code);
    end

    // Debounce break: three overs, an in-range 1400, then four overs trip.
    do_reset();
    for (int i = 0; i < 8; i++) feed(16'd1500);
    chk("db_warm_avg", s1_avg, 1500);
    for (int i = 0; i < 3; i++) begin
      feed(16'd1600);
      chk("db_over_a", over_limit, 1);
      chk("db_fault_a", fault, 0);
    end
    feed(16'd400);
    chk("db_break_avg", s1_avg, 1400);
    chk("db_break_over", over_limit, 0);
    chk("db_break_fault", fault, 0);
    for (int i = 0; i < 3; i++) begin
      feed(16'd4000);
      chk("db_over_b", over_limit, 1);
      chk("db_fault_b", fault, 0);
    end
    feed(16'd4000);
    chk("db_trip_fault", fault, 1);
    chk("db_trip_code", fault_code, 1);

    // Clear ignored while still over; accepted after the average recovers.
    pulse_clear();
    chk("clr_ignored_fault", fault, 1);
    chk("clr_ignored_code", fault_code, 1);
    for (int i = 0; i < 8; i++) feed(16'd1000);
    chk("clr_recov_avg", s1_avg, 1000);
    chk("clr_recov_over", over_limit, 0);
    chk("clr_held_fault", fault, 1);
    chk("clr_held_code", fault_code, 1);
    pulse_clear();
    chk("clr_ok_fault", fault, 0);
    chk("clr_ok_code", fault_code, 0);

    // Config error: immediate trip, not clearable until limits are consistent.
    @(negedge clk);
    thresh_lo = 14'd1600;
    repeat (2) @(negedge clk);
    chk("cfg_fault", fault, 1);
    chk("cfg_code", fault_code, 3);
    pulse_clear();
    chk("cfg_noclr_fault", fault, 1);
    @(negedge clk);
    thresh_lo = 14'd0;
    pulse_clear();
    chk("cfg_clr_fault", fault, 0);
    chk("cfg_clr_code", fault_code, 0);
    @(negedge clk);
    thresh_lo   = 14'd1600;
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    chk("cfg_tripwins_fault", fault, 1);
    chk("cfg_tripwins_code", fault_code, 3);
    @(negedge clk);
    thresh_lo = 14'd0;
    pulse_clear();
    chk("cfg_clr2_fault", fault, 0);

    // Under-limit trip with lo=1200 and averages of 1000.
    thresh_lo = 14'd1200;
    for (int i = 0; i < 3; i++) begin
      feed(16'd1000);
      chk("und_under", under_limit, 1);
      chk("und_over", over_limit, 0);
      chk("und_fault", fault, 0);
    end
    feed(16'd1000);
    chk("und_trip_fault", fault, 1);
    chk("und_trip_code", fault_code, 2);

    // Back-to-back stream of 100*k, k=1..20, with hi=1000, then reset mid-stream.
    do_reset();
    thresh_hi = 14'd1000;
    thresh_lo = 14'd0;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      sample_valid = 1'b1;
      sample_data  = 16'(100 * k);
      @(negedge clk);
      if (avg_valid) pulses++;
    end
    chk("b2b_pulses", pulses, 13);
    chk("b2b_avg", avg_value, 1650);
    chk("b2b_over", over_limit, 1);
    chk("b2b_fault", fault, 1);
    chk("b2b_code", fault_code, 1);
    sample_data = 16'd2100;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_avg_valid", avg_valid, 0);
    chk("mid_rst_avg_value", avg_value, 0);
    chk("mid_rst_over", over_limit, 0);
    chk("mid_rst_under", under_limit, 0);
    chk("mid_rst_fault", fault, 0);
    chk("mid_rst_code", fault_code, 0);
    sample_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      feed(16'd1000);
      chk("rewarm_no_valid", s1_av, 0);
    end
    feed(16'd1000);
    chk("rewarm_valid", s1_av, 1);
    chk("rewarm_avg", s1_avg, 1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
